frame_assemble: RTL and testbench

- Transmit-side counterpart of the subframe receiver. Serialises audio frames into a one-bit-per-strobe stream for the optical link.
- Each frame is two 28-bit subframes: channel A (out_channel=0), then channel B (out_channel=1). A block is 192 frames.
- Sits between the sample source (upstream) and the line driver (downstream).
- Builds the 192-bit channel-status block. The final byte of that block is a CRC-8 computed in-line.

---
 rtl/frame_assemble_pkg.sv | 20 ++
 rtl/frame_assemble_if.sv | 30 +++
 rtl/frame_assemble_crc.sv | 63 ++++++
 rtl/frame_assemble.sv | 203 ++++++++++++++++++++
 tb/tb_frame_assemble.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_assemble_pkg.sv
// Shared types and constants for the channel-status frame serialiser.
// Subframe slot names match the receiver so both sides read the same way.
package frame_pkg;

  typedef enum logic [2:0] {
    AUX,
    DATA,
    VALID,
    USER,
    CHANNEL,
    PARITY
  } subframe_state;

  localparam int unsigned SUBFRAME_BITS    = 28;
  localparam int unsigned FRAMES_PER_BLOCK = 192;
  localparam int unsigned STATUS_BYTES     = 24;
  localparam int unsigned STATUS_BITS      = STATUS_BYTES * 8;
  localparam int unsigned STATUS_DIN_BITS  = (STATUS_BYTES - 1) * 8;

endpackage

// File: rtl/frame_assemble_if.sv
// Sample-source and line-driver signals of the frame serialiser.
// The serialiser takes the slave view; whatever feeds it takes the master view.
interface frame_assemble_if;

  logic         sample_valid;
  logic         sample_ready;
  logic [19:0]  data_a;
  logic [19:0]  data_b;
  logic [3:0]   aux_a;
  logic [3:0]   aux_b;
  logic [183:0] status_din;
  logic         status_valid;
  logic         dout;
  logic         vout;
  logic [7:0]   frame_counter;
  logic         out_channel;
  logic         underrun;
  logic         block_done;

  modport master (
    output sample_valid, data_a, data_b, aux_a, aux_b, status_din, status_valid,
    input  sample_ready, dout, vout, frame_counter, out_channel, underrun, block_done
  );

  modport slave (
    input  sample_valid, data_a, data_b, aux_a, aux_b, status_din, status_valid,
    output sample_ready, dout, vout, frame_counter, out_channel, underrun, block_done
  );

endinterface

// File: rtl/frame_assemble_crc.sv
// Parameterised CRC engine; one full data word is folded in per valid_i.
// The register holds the unreflected remainder; reflection is applied at the edges.
module crc_calc #(
  parameter int unsigned                CRC_SIZE   = 8,
  parameter int unsigned                DATA_WIDTH = 8,
  parameter logic [CRC_SIZE-1:0]        POLY       = 8'h1D,
  parameter logic [CRC_SIZE-1:0]        INIT       = 8'hFF,
  parameter bit                         REF_IN     = 1'b1,
  parameter bit                         REF_OUT    = 1'b1,
  parameter logic [CRC_SIZE-1:0]        XOR_OUT    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_reset_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_SIZE-1:0]   crc_o
);

  logic [CRC_SIZE-1:0]   crc_q;
  logic [CRC_SIZE-1:0]   crc_next;
  logic [CRC_SIZE-1:0]   crc_work;
  logic [CRC_SIZE-1:0]   crc_refl;
  logic [DATA_WIDTH-1:0] din;
  logic                  fb;

  always_comb begin
    din = data_i;
    if (REF_IN) begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        din[i] = data_i[DATA_WIDTH-1-i];
      end
    end
    crc_work = crc_q;
    fb       = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      fb       = crc_work[CRC_SIZE-1] ^ din[DATA_WIDTH-1-i];
      crc_work = {crc_work[CRC_SIZE-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_next = crc_work;
  end

  always_comb begin
    crc_refl = crc_q;
    if (REF_OUT) begin
      for (int unsigned i = 0; i < CRC_SIZE; i++) begin
        crc_refl[i] = crc_q[CRC_SIZE-1-i];
      end
    end
    crc_o = crc_refl ^ XOR_OUT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= INIT;
    end else if (soft_reset_i) begin
      crc_q <= INIT;
    end else if (valid_i) begin
      crc_q <= crc_next;
    end
  end

endmodule

// File: rtl/frame_assemble.sv
// Serialises two-channel audio frames plus a 192-bit channel-status block
// (23 payload bytes and an in-line CRC-8) onto a one-bit-per-strobe stream.
module frame_assemble
  import frame_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 16,
  parameter logic [7:0]  CRC_POLY   = 8'h1D,
  parameter logic [7:0]  CRC_INIT   = 8'hFF
) (
  input logic             clk,
  input logic             rst,
  frame_assemble_if.slave bus
);

  localparam int unsigned   TW          = $clog2(BIT_PERIOD);
  localparam logic [TW-1:0] TC          = TW'(BIT_PERIOD - 1);
  localparam logic [7:0]    LAST_FRAME  = 8'(FRAMES_PER_BLOCK - 1);
  localparam logic [7:0]    CRC_FRAME   = 8'(STATUS_DIN_BITS);
  localparam logic [7:0]    LAST_STATUS = 8'(STATUS_BITS - 1);
  localparam logic [4:0]    LAST_BIT    = 5'(SUBFRAME_BITS - 1);
  localparam logic [4:0]    AUX_LAST    = 5'd3;
  localparam logic [4:0]    DATA_LAST   = 5'd23;

  logic [TW-1:0]              timer, timer_n;
  logic                       primed, primed_n, tick;
  subframe_state              state, state_n;
  logic [4:0]                 bit_idx, idx_n;
  logic                       ch, ch_n;
  logic [7:0]                 fc, fc_n;
  logic                       block_wrap, block_start, accept, starve;
  logic [19:0]                smp_data_a, smp_data_b, eff_data_a, eff_data_b, data_n;
  logic [3:0]                 smp_aux_a, smp_aux_b, eff_aux_a, eff_aux_b, aux_n;
  logic                       smp_invalid, eff_invalid;
  logic [STATUS_DIN_BITS-1:0] shadow;
  logic [STATUS_BITS-1:0]     status_full;
  logic                       par, par_n, bit_n;
  logic [6:0]                 cs_byte;
  logic                       feed_crc, byte_done;
  logic                       crc_soft, crc_valid;
  logic [7:0]                 crc_data, crc_val;
  logic                       dout_r, vout_r, ready_r, underrun_r, block_done_r;

  // Position/sample "next" values describe the bit loaded onto dout at the
  // coming terminal count; the first terminal count after reset only primes.
  always_comb begin
    tick        = (timer == TC);
    timer_n     = tick ? '0 : timer + 1'b1;
    primed_n    = primed | tick;
    block_wrap  = primed && (bit_idx == LAST_BIT) && ch && (fc == LAST_FRAME);
    block_start = !primed || block_wrap;
    accept      = tick && ready_r && bus.sample_valid;
    starve      = tick && ready_r && !bus.sample_valid;

    idx_n   = bit_idx + 1'b1;
    ch_n    = ch;
    fc_n    = fc;
    state_n = state;
    if (!primed) begin
      idx_n   = '0;
      ch_n    = 1'b0;
      fc_n    = '0;
      state_n = AUX;
    end else begin
      unique case (state)
        AUX:     state_n = (bit_idx == AUX_LAST)  ? DATA  : AUX;
        DATA:    state_n = (bit_idx == DATA_LAST) ? VALID : DATA;
        VALID:   state_n = USER;
        USER:    state_n = CHANNEL;
        CHANNEL: state_n = PARITY;
        PARITY:  state_n = AUX;
        default: state_n = AUX;
      endcase
      if (bit_idx == LAST_BIT) begin
        idx_n = '0;
        ch_n  = ~ch;
        if (ch) begin
          fc_n = (fc == LAST_FRAME) ? '0 : fc + 1'b1;
        end
      end
    end
  end

  always_comb begin
    eff_data_a  = smp_data_a;
    eff_data_b  = smp_data_b;
    eff_aux_a   = smp_aux_a;
    eff_aux_b   = smp_aux_b;
    eff_invalid = smp_invalid;
    if (accept) begin
      eff_data_a  = bus.data_a;
      eff_data_b  = bus.data_b;
      eff_aux_a   = bus.aux_a;
      eff_aux_b   = bus.aux_b;
      eff_invalid = 1'b0;
    end else if (starve) begin
      eff_data_a  = '0;
      eff_data_b  = '0;
      eff_aux_a   = '0;
      eff_aux_b   = '0;
      eff_invalid = 1'b1;
    end
    data_n      = ch_n ? eff_data_b : eff_data_a;
    aux_n       = ch_n ? eff_aux_b  : eff_aux_a;
    status_full = {shadow, crc_val};

    unique case (state_n)
      AUX:     bit_n = aux_n[2'(AUX_LAST - idx_n)];
      DATA:    bit_n = data_n[5'(DATA_LAST - idx_n)];
      VALID:   bit_n = eff_invalid;
      USER:    bit_n = 1'b0;
      CHANNEL: bit_n = status_full[LAST_STATUS - fc_n];
      PARITY:  bit_n = par;
      default: bit_n = 1'b0;
    endcase
    par_n     = (idx_n == '0) ? bit_n : (par ^ bit_n);
    feed_crc  = (state_n == CHANNEL) && !ch_n && (fc_n < CRC_FRAME);
    byte_done = (fc_n[2:0] == 3'b111);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer        <= '0;
      primed       <= 1'b0;
      state        <= AUX;
      bit_idx      <= '0;
      ch           <= 1'b0;
      fc           <= '0;
      smp_data_a   <= '0;
      smp_data_b   <= '0;
      smp_aux_a    <= '0;
      smp_aux_b    <= '0;
      smp_invalid  <= 1'b0;
      shadow       <= '0;
      par          <= 1'b0;
      cs_byte      <= '0;
      crc_soft     <= 1'b0;
      crc_valid    <= 1'b0;
      crc_data     <= '0;
      dout_r       <= 1'b0;
      vout_r       <= 1'b0;
      ready_r      <= 1'b0;
      underrun_r   <= 1'b0;
      block_done_r <= 1'b0;
    end else begin
      timer        <= timer_n;
      primed       <= primed_n;
      vout_r       <= primed_n && (timer_n == TC);
      // Position registers only move on tick, so at this edge they already
      // describe the bit that the upcoming strobe carries.
      ready_r      <= (timer_n == TC) && (!primed_n || ((bit_idx == LAST_BIT) && ch));
      underrun_r   <= starve;
      block_done_r <= tick && block_wrap;
      crc_soft     <= tick && block_start;
      crc_valid    <= tick && feed_crc && byte_done;
      if (tick) begin
        state       <= state_n;
        bit_idx     <= idx_n;
        ch          <= ch_n;
        fc          <= fc_n;
        dout_r      <= bit_n;
        par         <= par_n;
        smp_data_a  <= eff_data_a;
        smp_data_b  <= eff_data_b;
        smp_aux_a   <= eff_aux_a;
        smp_aux_b   <= eff_aux_b;
        smp_invalid <= eff_invalid;
        if (block_start && bus.status_valid) begin
          shadow <= bus.status_din;
        end
        if (feed_crc) begin
          cs_byte  <= {cs_byte[5:0], bit_n};
          crc_data <= {cs_byte, bit_n};
        end
      end
    end
  end

  crc_calc #(
    .CRC_SIZE   (8),
    .DATA_WIDTH (8),
    .POLY       (CRC_POLY),
    .INIT       (CRC_INIT),
    .REF_IN     (1'b1),
    .REF_OUT    (1'b1),
    .XOR_OUT    (8'h00)
  ) u_crc (
    .clk          (clk),
    .rst          (rst),
    .soft_reset_i (crc_soft),
    .valid_i      (crc_valid),
    .data_i       (crc_data),
    .crc_o        (crc_val)
  );

  assign bus.dout          = dout_r;
  assign bus.vout          = vout_r;
  assign bus.frame_counter = fc;
  assign bus.out_channel   = ch;
  assign bus.sample_ready  = ready_r;
  assign bus.underrun      = underrun_r;
  assign bus.block_done    = block_done_r;

endmodule

// File: tb/tb_frame_assemble.sv
// Directed bench for frame_assemble: per-frame expected bits are queued when a
// sample is handed over and compared against every vout strobe.
module tb_frame_assemble;
  import frame_pkg::*;

  localparam int unsigned BP                = 2;
  localparam int unsigned STROBES_PER_BLOCK = FRAMES_PER_BLOCK * 2 * SUBFRAME_BITS;

  typedef struct packed {
    logic       d;
    logic [7:0] fc;
    logic       ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  frame_assemble_if bus ();

  frame_assemble #(
    .BIT_PERIOD (BP),
    .CRC_POLY   (8'h1D),
    .CRC_INIT   (8'hFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int unsigned  strobes = 0;
  int           blk_done_cnt = 0;
  int           underrun_cnt = 0;
  bit           mon_en = 1'b0;
  logic [183:0] m_shadow;
  logic [7:0]   m_fc;
  exp_t         mon_e, mon_a;

  // Reflected (LSB-first) CRC-8, poly 0x1D reversed = 0xB8, seed 0xFF.
  function automatic logic [7:0] golden_crc(input logic [183:0] s);
    logic [7:0]   c;
    logic [183:0] t;
    c = 8'hFF;
    t = s;
    for (int b = 0; b < 23; b++) begin
      c = c ^ t[183:176];
      t = t << 8;
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 8'hB8) : (c >> 1);
      end
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      strobes = 0;
    end else if (mon_en) begin
      if (bus.vout) begin
        strobes++;
        mon_a.d  = bus.dout;
        mon_a.fc = bus.frame_counter;
        mon_a.ch = bus.out_channel;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $error("FAIL strobe_unexpected got=%0h exp=none", mon_a);
        end else begin
          mon_e = sb.pop_front();
          assert (mon_a === mon_e) else begin
            errors++;
            $error("FAIL bit strobe=%0d got d=%0b fc=%0d ch=%0b exp d=%0b fc=%0d ch=%0b",
                   strobes, mon_a.d, mon_a.fc, mon_a.ch, mon_e.d, mon_e.fc, mon_e.ch);
          end
        end
      end
      if (bus.block_done) begin
        blk_done_cnt++;
        checks++;
        assert (bus.frame_counter === 8'd0 && bus.out_channel === 1'b0 &&
                strobes != 0 && (strobes % STROBES_PER_BLOCK) == 0) else begin
          errors++;
          $error("FAIL block_done got fc=%0d ch=%0b strobes=%0d exp fc=0 ch=0 strobes=k*%0d",
                 bus.frame_counter, bus.out_channel, strobes, STROBES_PER_BLOCK);
        end
      end
      if (bus.underrun) underrun_cnt++;
    end
  end

  task automatic check_idle(input string tag);
    logic [13:0] got;
    got = {bus.dout, bus.vout, bus.frame_counter, bus.out_channel,
           bus.sample_ready, bus.underrun, bus.block_done};
    checks++;
    assert (got === 14'h0) else begin
      errors++;
      $error("FAIL %s outputs got=%0h exp=0", tag, got);
    end
  endtask

  task automatic do_frame(input logic sv, input logic [19:0] da, input logic [19:0] db,
                          input logic [3:0] aa, input logic [3:0] ab);
    int          n;
    logic [191:0] full;
    logic        sbit;
    logic [27:0] sf;
    logic [19:0] d;
    logic [3:0]  a;
    exp_t        e;
    bus.sample_valid = sv;
    bus.data_a = da;
    bus.data_b = db;
    bus.aux_a  = aa;
    bus.aux_b  = ab;
    n = 0;
    @(negedge clk);
    while (bus.sample_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (bus.sample_ready === 1'b1) else begin
      errors++;
      $error("FAIL ready_timeout frame=%0d got=%0b exp=1", m_fc, bus.sample_ready);
    end
    if (m_fc == 8'd0 && bus.status_valid) m_shadow = bus.status_din;
    full = {m_shadow, golden_crc(m_shadow)};
    sbit = full[191 - m_fc];
    for (int c = 0; c < 2; c++) begin
      d  = (!sv) ? 20'h0 : ((c == 0) ? da : db);
      a  = (!sv) ? 4'h0  : ((c == 0) ? aa : ab);
      sf = {a, d, !sv, 1'b0, sbit, 1'b0};
      sf[0] = ^sf[27:1];
      for (int i = 0; i < 28; i++) begin
        e.d  = sf[27-i];
        e.fc = m_fc;
        e.ch = (c == 1);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    assert (bus.underrun === !sv) else begin
      errors++;
      $error("FAIL underrun frame=%0d got=%0b exp=%0b", m_fc, bus.underrun, !sv);
    end
    checks++;
    assert (bus.sample_ready === 1'b0) else begin
      errors++;
      $error("FAIL ready_pulse frame=%0d got=%0b exp=0", m_fc, bus.sample_ready);
    end
    m_fc = (m_fc == 8'd191) ? 8'd0 : m_fc + 8'd1;
  endtask

  initial begin
    int n;
    int k;
    bus.sample_valid = 1'b0;
    bus.data_a       = '0;
    bus.data_b       = '0;
    bus.aux_a        = '0;
    bus.aux_b        = '0;
    bus.status_din   = '0;
    bus.status_valid = 1'b1;
    m_shadow         = '0;
    m_fc             = '0;

    repeat (3) @(negedge clk);
    check_idle("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    // Block 0: zero status; frame 3 starved; status changes mid-block.
    for (int f = 0; f < 192; f++) begin
      if (f == 100) bus.status_din = 184'({6{32'h5AC3_96E1}});
      if (f < 3)       do_frame(1'b1, 20'hABCDE, 20'h12345, 4'h5, 4'hA);
      else if (f == 3) do_frame(1'b0, 20'($urandom), 20'($urandom), 4'($urandom), 4'($urandom));
      else             do_frame(1'b1, 20'($urandom), 20'($urandom), 4'($urandom), 4'($urandom));
    end

    // Block 1 carries the new status; a later change without status_valid is ignored.
    for (int f = 0; f < 192; f++) begin
      if (f == 60) begin
        bus.status_valid = 1'b0;
        bus.status_din   = 184'({6{32'h0F0F_A55A}});
      end
      do_frame(1'b1, 20'($urandom), 20'($urandom), 4'($urandom), 4'($urandom));
    end

    // Block 2 up to frame 50, then reset while bit 12 of channel A is on the line.
    for (int f = 0; f <= 50; f++) begin
      do_frame(1'b1, 20'($urandom), 20'($urandom), 4'($urandom), 4'($urandom));
    end
    n = 0;
    k = 0;
    while (k < 13 && n < 1000) begin
      @(negedge clk);
      n++;
      if (bus.vout) k++;
    end
    checks++;
    assert (k == 13) else begin
      errors++;
      $error("FAIL abort_point got=%0d exp=13", k);
    end
    #1 rst = 1'b1;
    #1 check_idle("abort");
    sb.delete();
    m_fc     = '0;
    m_shadow = '0;
    repeat (3) @(negedge clk);
    check_idle("abort_hold");
    rst = 1'b0;

    for (int f = 0; f < 4; f++) begin
      do_frame(1'b1, 20'($urandom), 20'($urandom), 4'h9 ^ 4'(f), 4'($urandom));
    end

    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    mon_en = 1'b0;
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain got=%0d exp=0", sb.size());
    end
    checks++;
    assert (blk_done_cnt == 2) else begin
      errors++;
      $error("FAIL block_done_count got=%0d exp=2", blk_done_cnt);
    end
    checks++;
    assert (underrun_cnt == 1) else begin
      errors++;
      $error("FAIL underrun_count got=%0d exp=1", underrun_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
